detector_nota: RTL

DETECTOR_NOTA -- requirements
Module: detector_nota

---
 rtl/detector_nota.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/detector_nota.sv
// Musical-note detector: measures the period of an asynchronous square-wave tone and decodes it to one of seven keys.
// Optional two-period confirmation is compiled in with `define NOTA_CONFIRMACION_EN.
module detector_nota #(
  parameter int P_DO      = 191110,
  parameter int P_RE      = 170265,
  parameter int P_MI      = 151685,
  parameter int P_FA      = 143172,
  parameter int P_SOL     = 127551,
  parameter int P_LA      = 113636,
  parameter int P_SI      = 101239,
  parameter int TOL_SHIFT = 6,
  parameter int TIMEOUT   = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tono_in,
  output logic [6:0]  nota,
  output logic        valido,
  output logic [17:0] periodo
);

  typedef enum logic [1:0] {SILENCIO, PRIMER_FLANCO, MIDIENDO, VALIDO} state_t;

  localparam logic [17:0] C_PER [7] = '{18'(P_DO), 18'(P_RE), 18'(P_MI), 18'(P_FA),
                                        18'(P_SOL), 18'(P_LA), 18'(P_SI)};
  localparam logic [17:0] C_TIMEOUT = 18'(TIMEOUT);

  logic        r_sync1, r_sync2, r_hist;
  logic        w_edge;
  logic [17:0] r_count;
  logic        w_timeout;
  logic [6:0]  w_match;
  logic        w_hit;
  logic [2:0]  w_key;
  logic [6:0]  w_onehot;
  state_t      r_state, w_state_n;
  logic [6:0]  r_nota, w_nota_n;
  logic        r_valido, w_valido_n;
  logic [17:0] r_periodo, w_periodo_n;

  // NOTE: sequential state is always assigned with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= tono_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge    = r_sync2 & ~r_hist;
  assign w_timeout = (r_count == C_TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_count <= '0;
    else if (w_edge)     r_count <= 18'd1;
    else if (!w_timeout) r_count <= r_count + 18'd1;
  end

  // Unsigned absolute difference against each key's nominal period.
  for (genvar g = 0; g < 7; g++) begin : g_match
    logic [17:0] w_diff;
    assign w_diff     = (r_count >= C_PER[g]) ? (r_count - C_PER[g]) : (C_PER[g] - r_count);
    assign w_match[g] = (w_diff <= (C_PER[g] >> TOL_SHIFT));
  end

  assign w_hit = |w_match;

  always_comb begin
    w_key = '0;
    for (int k = 6; k >= 0; k--) begin
      if (w_match[k]) w_key = 3'(k);
    end
  end

  assign w_onehot = 7'd1 << w_key;

`ifdef NOTA_CONFIRMACION_EN
  logic [2:0] r_cand_key, w_cand_key_n;
  logic       r_cand_ok, w_cand_ok_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cand_key <= '0;
      r_cand_ok  <= 1'b0;
    end else begin
      r_cand_key <= w_cand_key_n;
      r_cand_ok  <= w_cand_ok_n;
    end
  end
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_n   = r_state;
    w_nota_n    = r_nota;
    w_valido_n  = r_valido;
    w_periodo_n = r_periodo;
`ifdef NOTA_CONFIRMACION_EN
    w_cand_key_n = r_cand_key;
    w_cand_ok_n  = r_cand_ok;
`endif
    if (w_edge) begin
      if (r_state == SILENCIO) begin
        w_state_n = PRIMER_FLANCO;
      end else begin
        w_periodo_n = r_count;
        if (!w_hit) begin
          w_state_n  = MIDIENDO;
          w_nota_n   = '0;
          w_valido_n = 1'b0;
`ifdef NOTA_CONFIRMACION_EN
          w_cand_ok_n = 1'b0;
`endif
        end else begin
`ifdef NOTA_CONFIRMACION_EN
          if (r_cand_ok && (r_cand_key == w_key)) begin
            w_state_n  = VALIDO;
            w_nota_n   = w_onehot;
            w_valido_n = 1'b1;
          end else begin
            w_cand_key_n = w_key;
            w_cand_ok_n  = 1'b1;
            w_state_n    = MIDIENDO;
            w_nota_n     = '0;
            w_valido_n   = 1'b0;
          end
`else
          w_state_n  = VALIDO;
          w_nota_n   = w_onehot;
          w_valido_n = 1'b1;
`endif
        end
      end
    end else if (w_timeout) begin
      w_state_n  = SILENCIO;
      w_nota_n   = '0;
      w_valido_n = 1'b0;
`ifdef NOTA_CONFIRMACION_EN
      w_cand_ok_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SILENCIO;
      r_nota    <= '0;
      r_valido  <= 1'b0;
      r_periodo <= '0;
    end else begin
      r_state   <= w_state_n;
      r_nota    <= w_nota_n;
      r_valido  <= w_valido_n;
      r_periodo <= w_periodo_n;
    end
  end

  assign nota    = r_nota;
  assign valido  = r_valido;
  assign periodo = r_periodo;

endmodule
